// File: rtl/lcd1602_responder_pkg.sv
// rtl/lcd1602_responder_pkg.sv - shared constants, opcodes and state encoding for the LCD1602 responder
package lcd1602_pkg;

   localparam int          LCD_CHARS      = 32;
   localparam int          CHARS_PER_LINE = 16;
   localparam logic [7:0]  BLANK_CHAR     = 8'h20;

   localparam logic [7:0]  CLEAR_DISPLAY             = 8'h01;
   localparam logic [7:0]  RETURN_HOME               = 8'h02;
   localparam logic [7:0]  SHIFT_CURSOR_RIGHT        = 8'h06;
   localparam logic [7:0]  DISPON_CURSOROFF          = 8'h0C;
   localparam logic [7:0]  LINES2_MATRIX5x8_MODE8bit = 8'h38;
   localparam logic [7:0]  START_2LINE               = 8'hC0;

   typedef enum logic [1:0] {
      ST_CLEARING,
      ST_IDLE,
      ST_EXEC,
      ST_BUSY
   } state_e;

   function automatic logic [4:0] step_cursor(input logic [4:0] idx, input logic inc);
      return inc ? idx + 5'd1 : idx - 5'd1;
   endfunction

endpackage

// File: rtl/lcd1602_responder_if.sv
// rtl/lcd1602_responder_if.sv - 8-bit parallel LCD bus between controller (master) and display (slave)
interface lcd1602_responder_if;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_enable;
   logic [7:0] lcd_data;
   logic [7:0] lcd_dout;

   modport master (output lcd_rs, output lcd_rw, output lcd_enable, output lcd_data, input lcd_dout);
   modport slave  (input lcd_rs, input lcd_rw, input lcd_enable, input lcd_data, output lcd_dout);
endinterface

// File: rtl/lcd1602_responder_bus_sync.sv
// rtl/lcd1602_responder_bus_sync.sv - bus synchronizer with enable falling-edge strobe
module lcd_bus_sync #(
   parameter int STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_in,
   input  logic       rs_in,
   input  logic       rw_in,
   input  logic [7:0] data_in,
   output logic       strobe,
   output logic       rs,
   output logic       rw,
   output logic [7:0] data
);

   // Bit 10 = enable, 9 = rs, 8 = rw, 7:0 = data
   logic [10:0] sync_q [STAGES];
   logic [10:0] sync_d [STAGES];
   logic        en_prev_q;
   logic        en_prev_d;

   always_comb begin
      sync_d[0] = {enable_in, rs_in, rw_in, data_in};
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      en_prev_d = sync_q[STAGES-1][10];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
         en_prev_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         en_prev_q <= en_prev_d;
      end
   end

   assign strobe = en_prev_q & ~sync_q[STAGES-1][10];
   assign rs     = sync_q[STAGES-1][9];
   assign rw     = sync_q[STAGES-1][8];
   assign data   = sync_q[STAGES-1][7:0];

endmodule

// File: rtl/lcd1602_responder.sv
// rtl/lcd1602_responder.sv - HD44780-style 16x2 display target: decode, buffer, cursor and busy model
module lcd1602_responder
   import lcd1602_pkg::*;
#(
   parameter int BUSY_SHORT  = 2,
   parameter int BUSY_LONG   = 40,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   lcd1602_responder_if.slave   bus,
   input  logic [4:0]           rd_addr,
   output logic [7:0]           rd_char,
   output logic [4:0]           cursor_idx,
   output logic                 display_on,
   output logic                 cursor_on,
   output logic                 blink_on,
   output logic                 two_line,
   output logic                 inc_mode,
   output logic                 busy,
   output logic                 cmd_valid,
   output logic                 cmd_rs,
   output logic [7:0]           cmd_byte,
   output logic                 overrun,
   output logic                 unsupported
);

   localparam int CNT_W = $clog2(BUSY_LONG + 1);
   // EXEC is itself one busy cycle and BUSY lasts count+1 cycles, hence the -2;
   // after clearing, the 32 CLEARING cycles plus count+1 make up BUSY_LONG.
   localparam logic [CNT_W-1:0] CNT_SHORT     = CNT_W'(BUSY_SHORT - 2);
   localparam logic [CNT_W-1:0] CNT_LONG      = CNT_W'(BUSY_LONG - 2);
   localparam logic [CNT_W-1:0] CNT_AFTER_CLR = CNT_W'(BUSY_LONG - 33);

   logic       strobe, s_rs, s_rw;
   logic [7:0] s_data;

   lcd_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .enable_in (bus.lcd_enable),
      .rs_in     (bus.lcd_rs),
      .rw_in     (bus.lcd_rw),
      .data_in   (bus.lcd_data),
      .strobe    (strobe),
      .rs        (s_rs),
      .rw        (s_rw),
      .data      (s_data)
   );

   state_e           state_q, state_d;
   logic [4:0]       clr_cnt_q, clr_cnt_d;
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic [4:0]       cursor_q, cursor_d;
   logic             display_on_q, display_on_d, cursor_on_q, cursor_on_d;
   logic             blink_on_q, blink_on_d, two_line_q, two_line_d;
   logic             inc_mode_q, inc_mode_d;
   logic             cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
   logic [7:0]       cmd_byte_q, cmd_byte_d;
   logic             overrun_q, overrun_d, unsupported_q, unsupported_d;
   logic [7:0]       rd_char_q;
   logic [7:0]       mem_q [LCD_CHARS];
   logic             wr_en;
   logic [4:0]       wr_idx;
   logic [7:0]       wr_data;

   always_comb begin
      state_d       = state_q;
      clr_cnt_d     = clr_cnt_q;
      busy_cnt_d    = busy_cnt_q;
      cursor_d      = cursor_q;
      display_on_d  = display_on_q;
      cursor_on_d   = cursor_on_q;
      blink_on_d    = blink_on_q;
      two_line_d    = two_line_q;
      inc_mode_d    = inc_mode_q;
      cmd_valid_d   = 1'b0;
      cmd_rs_d      = cmd_rs_q;
      cmd_byte_d    = cmd_byte_q;
      overrun_d     = overrun_q;
      unsupported_d = unsupported_q;
      wr_en         = 1'b0;
      wr_idx        = cursor_q;
      wr_data       = cmd_byte_q;

      if (strobe && state_q != ST_IDLE) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_CLEARING: begin
            wr_en     = 1'b1;
            wr_idx    = clr_cnt_q;
            wr_data   = BLANK_CHAR;
            clr_cnt_d = clr_cnt_q + 5'd1;
            if (clr_cnt_q == 5'(LCD_CHARS - 1)) begin
               cursor_d   = 5'd0;
               busy_cnt_d = CNT_AFTER_CLR;
               state_d    = ST_BUSY;
            end
         end
         ST_IDLE: begin
            if (strobe && !s_rw) begin
               cmd_valid_d = 1'b1;
               cmd_rs_d    = s_rs;
               cmd_byte_d  = s_data;
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d    = ST_BUSY;
            busy_cnt_d = CNT_SHORT;
            if (cmd_rs_q) begin
               wr_en    = 1'b1;
               cursor_d = step_cursor(cursor_q, inc_mode_q);
            end else if (cmd_byte_q[7]) begin
               cursor_d = {cmd_byte_q[6], cmd_byte_q[3:0]};
            end else if (cmd_byte_q[6]) begin
               cursor_d = cursor_q;
            end else if (cmd_byte_q[5]) begin
               two_line_d = cmd_byte_q[3];
               if (!cmd_byte_q[4]) begin
                  unsupported_d = 1'b1;
               end
            end else if (cmd_byte_q[4]) begin
               if (!cmd_byte_q[3]) begin
                  cursor_d = step_cursor(cursor_q, cmd_byte_q[2]);
               end
            end else if (cmd_byte_q[3]) begin
               display_on_d = cmd_byte_q[2];
               cursor_on_d  = cmd_byte_q[1];
               blink_on_d   = cmd_byte_q[0];
            end else if (cmd_byte_q[2]) begin
               inc_mode_d = cmd_byte_q[1];
            end else if (cmd_byte_q[1]) begin
               cursor_d   = 5'd0;
               busy_cnt_d = CNT_LONG;
            end else if (cmd_byte_q[0]) begin
               inc_mode_d = 1'b1;
               clr_cnt_d  = 5'd0;
               state_d    = ST_CLEARING;
            end
         end
         ST_BUSY: begin
            if (busy_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               busy_cnt_d = busy_cnt_q - 1'b1;
            end
         end
         default: state_d = ST_CLEARING;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_CLEARING;
         clr_cnt_q     <= 5'd0;
         busy_cnt_q    <= '0;
         cursor_q      <= 5'd0;
         display_on_q  <= 1'b0;
         cursor_on_q   <= 1'b0;
         blink_on_q    <= 1'b0;
         two_line_q    <= 1'b0;
         inc_mode_q    <= 1'b1;
         cmd_valid_q   <= 1'b0;
         cmd_rs_q      <= 1'b0;
         cmd_byte_q    <= 8'h00;
         overrun_q     <= 1'b0;
         unsupported_q <= 1'b0;
         rd_char_q     <= 8'h00;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         busy_cnt_q    <= busy_cnt_d;
         cursor_q      <= cursor_d;
         display_on_q  <= display_on_d;
         cursor_on_q   <= cursor_on_d;
         blink_on_q    <= blink_on_d;
         two_line_q    <= two_line_d;
         inc_mode_q    <= inc_mode_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_rs_q      <= cmd_rs_d;
         cmd_byte_q    <= cmd_byte_d;
         overrun_q     <= overrun_d;
         unsupported_q <= unsupported_d;
         rd_char_q     <= mem_q[rd_addr];
      end
   end

   // Buffer is not reset; CLEARING blanks it after every reset
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign bus.lcd_dout = {busy, cursor_q[4], 2'b00, cursor_q[3:0]};
   assign rd_char      = rd_char_q;
   assign cursor_idx   = cursor_q;
   assign display_on   = display_on_q;
   assign cursor_on    = cursor_on_q;
   assign blink_on     = blink_on_q;
   assign two_line     = two_line_q;
   assign inc_mode     = inc_mode_q;
   assign cmd_valid    = cmd_valid_q;
   assign cmd_rs       = cmd_rs_q;
   assign cmd_byte     = cmd_byte_q;
   assign overrun      = overrun_q;
   assign unsupported  = unsupported_q;

endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- Synthesizable HD44780-style LCD 16x2 target that receives the 8-bit parallel bus (rs, rw, enable, data) driven by the LCD1602 controller.
- Decodes instructions, holds a 32-character display buffer, tracks cursor and display flags, and models the busy flag.
- Used as the bench-side/loopback end for controller verification and as a source for an on-chip display mirror (read port).

Parameters:
- BUSY_SHORT, 2, clk cycles busy after any accepted transaction other than clear/home.
- BUSY_LONG, 40, clk cycles busy after clear (0x01) or return-home (0x02); must be ≥ 33.
- SYNC_STAGES, 2, synchronizer depth on lcd_enable, lcd_rs, lcd_rw and lcd_data.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- lcd_rs  in  1  0 = instruction, 1 = data
- lcd_rw  in  1  0 = write, 1 = read
- lcd_enable  in  1  strobe; a transaction is sampled on its falling edge
- lcd_data  in  8  bus value
- lcd_dout  out  8  read response: {busy, cursor address as 7-bit DDRAM value}
- rd_addr  in  5  mirror read index (0–15 line 1, 16–31 line 2)
- rd_char  out  8  buffer[rd_addr], registered, 1-cycle latency
- cursor_idx  out  5  current cursor index
- display_on, cursor_on, blink_on, two_line, inc_mode  out  1 each  decoded flags
- busy  out  1  busy flag
- cmd_valid  out  1  one-cycle pulse per accepted transaction
- cmd_rs  out  1  rs of the last accepted transaction
- cmd_byte  out  8  byte of the last accepted transaction
- overrun  out  1  sticky; set when a transaction arrives while busy
- unsupported  out  1  sticky; set by function set with DL = 0

Behaviour:
- **Synchronization:** All bus inputs pass through SYNC_STAGES flops. A falling edge is enable_sync 1→0. rs, rw and data are taken from the synchronized copies on that cycle. An effect is visible on the outputs ≤ SYNC_STAGES + 2 clk cycles after lcd_enable falls.
- **Reset (reset == 0 at posedge clk):**
  - cursor_idx = 0, busy = 1.
  - All flags 0 except inc_mode = 1.
  - cmd_valid, cmd_rs, cmd_byte, overrun, unsupported, rd_char = 0.
  - lcd_dout = 0x80.
  - The FSM enters CLEARING.
  - Reset mid-operation aborts any clear or busy count.
- **FSM states: CLEARING, IDLE, EXEC, BUSY.**
  - CLEARING writes 0x20 to index clr_cnt, 0..31, one per cycle. It then sets cursor_idx = 0 and goes to BUSY with the remaining count, so that total busy = BUSY_LONG.
  - IDLE, on a falling edge with rw = 0: latch the transaction, pulse cmd_valid, go to EXEC.
  - IDLE, on a falling edge with rw = 1: no state change; lcd_dout is already valid combinationally from the registers.
  - EXEC (1 cycle) applies the transaction, loads the busy counter, then goes to BUSY or CLEARING.
  - BUSY counts down to 0, then returns to IDLE.
  - busy = 1 in every state except IDLE.
- **Falling edge while not in IDLE:** the transaction is discarded, overrun is set, and cmd_valid does not pulse.
- **Instruction decode (rs = 0), by highest set bit:**
  - 0x01 clear: go to CLEARING, which also sets cursor_idx = 0 and inc_mode = 1.
  - 0x02/0x03 home: cursor_idx = 0; BUSY_LONG.
  - 0x04–0x07 entry: inc_mode = bit1; bit0 (display shift) is ignored.
  - 0x08–0x0F display: display_on = bit2, cursor_on = bit1, blink_on = bit0.
  - 0x10–0x1F shift: if bit3 == 0, the cursor moves +1 when bit2 = 1 and −1 when bit2 = 0; display shift is ignored.
  - 0x20–0x3F function set: two_line = bit3; if bit4 == 0, set unsupported (flags otherwise unchanged).
  - 0x40–0x7F CGRAM address: accepted, no effect.
  - 0x80–0xFF DDRAM address: cursor_idx = {data[6], data[3:0]}; bits 5:4 are ignored.
- **Data write (rs = 1):** buffer[cursor_idx] = data, then the cursor advances by ±1 per inc_mode.
- **Cursor arithmetic:** 5-bit modulo 32. Increment wraps 31→0 and decrement wraps 0→31; 15→16 crosses to line 2.
- **lcd_dout:** {busy, cursor_idx[4], 2'b00, cursor_idx[3:0]}, i.e. line-2 indices read back as 0x40+col.
- **Read port:** independent of the FSM. A write and a read of the same index in the same cycle returns the old value.

Decomposition:
- Package lcd1602_pkg holds:
  - instruction opcode constants (CLEAR_DISPLAY 0x01, RETURN_HOME 0x02, SHIFT_CURSOR_RIGHT 0x06, DISPON_CURSOROFF 0x0C, LINES2_MATRIX5x8_MODE8bit 0x38, START_2LINE 0xC0);
  - the state encoding;
  - LCD_CHARS = 32, CHARS_PER_LINE = 16, BLANK_CHAR = 0x20.
- Sub-module lcd_bus_sync: synchronizer plus falling-edge detector, outputting a strobe and the captured rs, rw and data.

Test Plan:
- Release reset, hold the bus idle → busy = 1 for BUSY_LONG cycles; afterwards rd_char = 0x20 for all 32 indices, cursor_idx = 0, lcd_dout = 0x00.
- Send 0x38, 0x06, 0x0C, 0x01, then 16 data bytes "HELLO WORLD     ", then 0xC0, then 16 bytes → two_line = 1, display_on = 1, cursor_on = 0, inc_mode = 1; rd_char[0..15] and [16..31] match; final cursor_idx = 0 (wrap).
- Send 0x85, then data 0x41 → buffer[5] = 0x41; cursor_idx = 6; lcd_dout reads 0x06 when idle.
- Send 0x04, then 0x80, then data 0x42 → buffer[0] = 0x42; cursor_idx = 31; a 0x14 shift then returns it to 0.
- Issue a second enable strobe 1 cycle after 0x01 is accepted → overrun = 1, second byte not applied, cmd_valid pulses exactly once.
- Assert reset midway through CLEARING (after 10 entries) → FSM restarts CLEARING; 0x20 in all entries; overrun and unsupported both 0.
- Send 0x28 → unsupported = 1, two_line = 1.
